stepper_drive_ctrl: RTL and testbench
=====================================

// Module: stepper_drive_ctrl
// PURPOSE
//  Sequences stepper coils from the 3-bit speed level (1..6) of the speed selector.
//  Ramps the actual level toward the target one level at a time and times steps with a per-level period.
//  Decelerates to level 1 before stopping or reversing; drives coil phase pattern, step strobe, status.
// PARAMETERS
//  BASE_DIV    1000  clocks per period unit; step period = BASE_DIV*(7-cur_speed); legal 1..2^20
//  RAMP_STEPS  4     steps taken at a level before moving one level toward goal; legal 1..255
//  HALF_STEP   0     0: 4-phase full-step (two coils on); 1: 8-phase half-step
// PORTS
//  clk           in   1  system clock, all state on rising edge
//  resetb        in   1  asynchronous reset, active-low
//  run_en        in   1  1 = run motor, 0 = decelerate and stop
//  dir           in   1  requested direction, 1 = forward (phase index +1), 0 = reverse (-1)
//  target_speed  in   3  requested level; 0 treated as 1, 7 treated as 6
//  coil          out  4  coil drive pattern, 0000 when idle
//  step_pulse    out  1  one-clock strobe on each phase advance
//  cur_speed     out  3  actual level 1..6 while busy, 0 when idle
//  busy          out  1  state != IDLE
//  at_speed      out  1  state RUN and cur_speed == clamped target_speed
// BEHAVIOUR
//  Reset (async, resetb=0): state IDLE, coil=0, step_pulse=0, cur_speed=0, busy=0, at_speed=0,
//   phase idx=0, run_dir=0, step_cnt=0, period counter=0. Coils drop immediately, mid-move included.
//  All outputs registered. States: IDLE, RUN, STOP, REV. goal = clamped target in RUN, 1 in STOP/REV.
//  IDLE: run_en=1 -> RUN next clock: cur_speed=1, run_dir<=dir, counter<=6*BASE_DIV-1, step_cnt=0,
//   coil=pattern[idx] (idx held from last move). First step_pulse 6*BASE_DIV clocks after entry.
//  Period counter counts down in RUN/STOP/REV; at 0: step_pulse=1 that clock, idx += run_dir?+1:-1
//   (mod 4 or 8), coil updates same clock, counter reloads with period of the level after update.
//  Ramp, evaluated only on a step: cur_speed==goal -> step_cnt=0; else if step_cnt==RAMP_STEPS-1 ->
//   cur_speed moves 1 toward goal, step_cnt=0; else step_cnt+1. Never outside 1..6.
//  RUN: run_en=0 -> STOP; else dir!=run_dir -> REV; target changes retarget goal without stopping.
//  STOP: step taken with cur_speed==1 (value before update) -> IDLE next clock: coil=0, cur_speed=0.
//   run_en=1 again -> RUN if dir==run_dir else REV; speed continues from current level.
//  REV: step taken with cur_speed==1 uses old run_dir, then run_dir<=dir, state RUN; run_en=0 -> STOP.
//  Simultaneous step and run_en/dir change: step completes under current-state rules; state moves next clock.
//  Full-step patterns idx0..3: 0011,0110,1100,1001. Half-step idx0..7:
//   0001,0011,0010,0110,0100,1100,1000,1001.
//  Counter width = clog2(6*BASE_DIV); no overflow at any legal parameter value.
// TESTING (BASE_DIV=4, RAMP_STEPS=2, HALF_STEP=0 unless noted)
//  Reset mid-RUN at level 3 -> same-time coil=0000, cur_speed=0, busy=0, step_pulse=0; idx restarts 0.
//  run_en=1,dir=1,target=3 from IDLE -> next clk busy=1,cur_speed=1,coil=0011; step 24 clk later,
//   coil=0110; after 2 steps cur_speed=2 (period 20), after 4 steps 3 (period 16), at_speed=1.
//  At level 3, run_en=0 -> at_speed=0; levels 3->2->1 every 2 steps; next step at level 1 -> IDLE,
//   coil=0000, cur_speed=0, busy=0.
//  At level 6 fwd, dir->0 -> decel to 1 with coil still advancing forward; step at level 1 forward, then
//   reverse order (e.g. 0110->0011->1001), accelerates back to 6, at_speed=1.
//  target=7 -> ramps to 6; target=0 -> holds 1; target 6->2 mid-run -> decel to 2, no stop, busy=1.
//  HALF_STEP=1, dir=1, 8 steps -> coil 0001,0011,0010,0110,0100,1100,1000,1001 then 0001.

Source files
------------

// File: rtl/stepper_drive_ctrl.sv
// Stepper coil sequencer: ramps the actual speed level toward a goal one level at a time,
// times phase advances with a per-level period, and decelerates to level 1 before stop/reverse.
module stepper_drive_ctrl #(
   parameter int BASE_DIV   = 1000,
   parameter int RAMP_STEPS = 4,
   parameter bit HALF_STEP  = 1'b0
) (
   input  logic       clk,
   input  logic       resetb,
   input  logic       run_en,
   input  logic       dir,
   input  logic [2:0] target_speed,
   output logic [3:0] coil,
   output logic       step_pulse,
   output logic [2:0] cur_speed,
   output logic       busy,
   output logic       at_speed
);

   localparam int         CW       = $clog2(6*BASE_DIV);
   localparam logic [2:0] IDX_MASK = HALF_STEP ? 3'd7 : 3'd3;
   localparam logic [7:0] RAMP_LST = 8'(RAMP_STEPS-1);

   typedef enum logic [1:0] {IDLE, RUN, STOP, REV} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    idx, idx_n, lvl_n, goal, tgt;
   logic [7:0]    scnt, scnt_n;
   logic          run_dir, run_dir_n;
   logic          step;

   // Reload value is one less than the period so the step lands exactly one period later.
   function automatic logic [CW-1:0] period_m1(input logic [2:0] lvl);
      int p;
      p = BASE_DIV * (7 - int'(lvl)) - 1;
      return CW'(p);
   endfunction

   function automatic logic [3:0] pattern(input logic [2:0] i);
      logic [3:0] c;
      c = 4'b0000;
      if (HALF_STEP) begin
         case (i)
            3'd0: c = 4'b0001;
            3'd1: c = 4'b0011;
            3'd2: c = 4'b0010;
            3'd3: c = 4'b0110;
            3'd4: c = 4'b0100;
            3'd5: c = 4'b1100;
            3'd6: c = 4'b1000;
            default: c = 4'b1001;
         endcase
      end else begin
         case (i[1:0])
            2'd0: c = 4'b0011;
            2'd1: c = 4'b0110;
            2'd2: c = 4'b1100;
            default: c = 4'b1001;
         endcase
      end
      return c;
   endfunction

   always_comb begin
      tgt       = (target_speed == 3'd0) ? 3'd1 :
                  (target_speed == 3'd7) ? 3'd6 : target_speed;
      goal      = (state == RUN) ? tgt : 3'd1;
      step      = (state != IDLE) && (cnt == '0);
      state_n   = state;
      cnt_n     = cnt;
      idx_n     = idx;
      lvl_n     = cur_speed;
      scnt_n    = scnt;
      run_dir_n = run_dir;

      if (state == IDLE) begin
         if (run_en) begin
            state_n   = RUN;
            lvl_n     = 3'd1;
            run_dir_n = dir;
            cnt_n     = period_m1(3'd1);
            scnt_n    = '0;
         end
      end else begin
         cnt_n = cnt - 1'b1;
         if (step) begin
            idx_n = (run_dir ? idx + 3'd1 : idx - 3'd1) & IDX_MASK;
            if (cur_speed == goal) begin
               scnt_n = '0;
            end else if (scnt == RAMP_LST) begin
               lvl_n  = (cur_speed < goal) ? cur_speed + 3'd1 : cur_speed - 3'd1;
               scnt_n = '0;
            end else begin
               scnt_n = scnt + 8'd1;
            end
            cnt_n = period_m1(lvl_n);
         end

         // A step on this clock resolves under the current state; input changes act next clock.
         case (state)
            RUN: begin
               if (!run_en)             state_n = STOP;
               else if (dir != run_dir) state_n = REV;
            end
            STOP: begin
               if (step && cur_speed == 3'd1) begin
                  state_n = IDLE;
                  lvl_n   = 3'd0;
                  cnt_n   = '0;
                  scnt_n  = '0;
               end else if (run_en) begin
                  state_n = (dir == run_dir) ? RUN : REV;
               end
            end
            REV: begin
               if (step && cur_speed == 3'd1) begin
                  state_n   = RUN;
                  run_dir_n = dir;
               end else if (!run_en) begin
                  state_n = STOP;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         scnt       <= '0;
         run_dir    <= 1'b0;
         coil       <= 4'b0000;
         step_pulse <= 1'b0;
         cur_speed  <= 3'd0;
         busy       <= 1'b0;
         at_speed   <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         idx        <= idx_n;
         scnt       <= scnt_n;
         run_dir    <= run_dir_n;
         coil       <= (state_n == IDLE) ? 4'b0000 : pattern(idx_n);
         step_pulse <= step;
         cur_speed  <= lvl_n;
         busy       <= (state_n != IDLE);
         at_speed   <= (state_n == RUN) && (lvl_n == tgt);
      end
   end

endmodule

// File: tb/tb_stepper_drive_ctrl.sv
// Bench for stepper_drive_ctrl: an event-time model (next-step due cycle, integer phase position)
// checked every cycle against a full-step and a half-step instance, plus directed literal checks.
module tb_stepper_drive_ctrl;

   localparam int BD = 4;
   localparam int RS = 2;

   logic       clk = 1'b0;
   logic       resetb;
   logic       run_en, dir;
   logic [2:0] target_speed;
   logic [3:0] coil_f, coil_h;
   logic       pulse_f, pulse_h, busy_f, busy_h, at_f, at_h;
   logic [2:0] cur_f, cur_h;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   stepper_drive_ctrl #(.BASE_DIV(BD), .RAMP_STEPS(RS), .HALF_STEP(1'b0)) dut (
      .clk(clk), .resetb(resetb), .run_en(run_en), .dir(dir), .target_speed(target_speed),
      .coil(coil_f), .step_pulse(pulse_f), .cur_speed(cur_f), .busy(busy_f), .at_speed(at_f));

   stepper_drive_ctrl #(.BASE_DIV(BD), .RAMP_STEPS(RS), .HALF_STEP(1'b1)) dut_h (
      .clk(clk), .resetb(resetb), .run_en(run_en), .dir(dir), .target_speed(target_speed),
      .coil(coil_h), .step_pulse(pulse_h), .cur_speed(cur_h), .busy(busy_h), .at_speed(at_h));

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [3:0] full_tab [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
   logic [3:0] half_tab [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                4'b0100, 4'b1100, 4'b1000, 4'b1001};

   // mode: 0 idle, 1 run, 2 stop, 3 reverse
   int m_mode = 0, m_lvl = 0, m_pos = 0, m_dir = 0, m_due = 0, m_cnt = 0, cyc = 0;
   bit m_pulse = 1'b0, m_at = 1'b0;

   function automatic int clampt(input logic [2:0] t);
      if (t == 3'd0) return 1;
      if (t == 3'd7) return 6;
      return int'(t);
   endfunction

   always @(posedge clk or negedge resetb) begin
      int tgt, goal, omode, olvl;
      bit st;
      if (!resetb) begin
         m_mode = 0; m_lvl = 0; m_pos = 0; m_dir = 0; m_due = 0; m_cnt = 0; cyc = 0;
         m_pulse = 1'b0; m_at = 1'b0;
      end else begin
         cyc++;
         tgt   = clampt(target_speed);
         st    = (m_mode != 0) && (cyc == m_due);
         omode = m_mode;
         olvl  = m_lvl;
         m_pulse = st;
         if (m_mode == 0) begin
            if (run_en) begin
               m_mode = 1; m_lvl = 1; m_dir = int'(dir); m_cnt = 0; m_due = cyc + 6*BD;
            end
         end else begin
            if (st) begin
               m_pos = (m_pos + ((m_dir != 0) ? 1 : 7)) % 8;
               goal  = (omode == 1) ? tgt : 1;
               if (m_lvl == goal) m_cnt = 0;
               else begin
                  m_cnt++;
                  if (m_cnt == RS) begin
                     m_lvl += (goal > m_lvl) ? 1 : -1;
                     m_cnt = 0;
                  end
               end
               m_due = cyc + BD*(7 - m_lvl);
            end
            case (omode)
               1: if (!run_en) m_mode = 2; else if (int'(dir) != m_dir) m_mode = 3;
               2: if (st && olvl == 1) begin m_mode = 0; m_lvl = 0; m_cnt = 0; end
                  else if (run_en) m_mode = (int'(dir) == m_dir) ? 1 : 3;
               3: if (st && olvl == 1) begin m_mode = 1; m_dir = int'(dir); end
                  else if (!run_en) m_mode = 2;
               default: ;
            endcase
         end
         m_at = (m_mode == 1) && (m_lvl == tgt);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("coil_full", int'(coil_f), (m_mode == 0) ? 0 : int'(full_tab[m_pos % 4]));
         check("coil_half", int'(coil_h), (m_mode == 0) ? 0 : int'(half_tab[m_pos]));
         check("step_pulse", int'(pulse_f), int'(m_pulse));
         check("step_pulse_h", int'(pulse_h), int'(m_pulse));
         check("cur_speed", int'(cur_f), m_lvl);
         check("busy", int'(busy_f), int'(m_mode != 0));
         check("at_speed", int'(at_f), int'(m_at));
         check("cur_speed_h", int'(cur_h), m_lvl);
      end
   end

   // ---------------- directed stimulus ----------------
   function automatic logic [3:0] rotl(input logic [3:0] c);
      return {c[2:0], c[3]};
   endfunction
   function automatic logic [3:0] rotr(input logic [3:0] c);
      return {c[0], c[3:1]};
   endfunction

   task automatic wait_pulse(input int bound, output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!pulse_f && n < bound);
      if (!pulse_f) check("pulse_timeout", 0, 1);
   endtask

   // kind 0: busy low, 1: at_speed high, 2: cur_speed == val
   task automatic wait_for(input int kind, input int val, input int bound);
      int n;
      bit ok;
      n = 0;
      ok = 1'b0;
      while (!ok && n < bound) begin
         @(negedge clk);
         n++;
         case (kind)
            0: ok = !busy_f;
            1: ok = at_f;
            default: ok = (int'(cur_f) == val);
         endcase
      end
      if (!ok) check($sformatf("wait_timeout_kind%0d", kind), 0, 1);
   endtask

   initial begin
      int n, npulse;
      logic [3:0] prev;
      logic [3:0] hexp [9];
      hexp = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100,
               4'b1100, 4'b1000, 4'b1001, 4'b0001};

      resetb = 1'b0; run_en = 1'b0; dir = 1'b0; target_speed = 3'd0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("rst_coil", int'(coil_f), 0);
      check("rst_busy", int'(busy_f), 0);
      check("rst_cur", int'(cur_f), 0);
      resetb = 1'b1;
      @(negedge clk);

      // start forward toward level 3
      run_en = 1'b1; dir = 1'b1; target_speed = 3'd3;
      @(negedge clk);
      check("start_busy", int'(busy_f), 1);
      check("start_cur", int'(cur_f), 1);
      check("start_coil", int'(coil_f), 4'b0011);
      check("start_coil_h", int'(coil_h), 4'b0001);
      wait_pulse(100, n);
      check("first_step_delay", n, 24);
      check("first_step_coil", int'(coil_f), 4'b0110);
      wait_pulse(100, n);
      check("lvl_after_2", int'(cur_f), 2);
      wait_pulse(100, n);
      check("period_lvl2", n, 20);
      wait_pulse(100, n);
      check("lvl_after_4", int'(cur_f), 3);
      check("at_speed_3", int'(at_f), 1);
      wait_pulse(100, n);
      check("period_lvl3", n, 16);

      // decelerate and stop: 2 steps at 3, 2 at 2, final step at 1
      run_en = 1'b0;
      @(negedge clk);
      check("stop_at_speed", int'(at_f), 0);
      npulse = 0;
      n = 0;
      while (busy_f && n < 500) begin
         @(negedge clk);
         n++;
         if (pulse_f) npulse++;
      end
      check("stop_pulses", npulse, 5);
      check("stop_last_pulse", int'(pulse_f), 1);
      check("idle_coil", int'(coil_f), 0);
      check("idle_cur", int'(cur_f), 0);
      check("idle_busy", int'(busy_f), 0);

      // target 7 clamps to 6, then reverse through level 1
      run_en = 1'b1; dir = 1'b1; target_speed = 3'd7;
      wait_for(1, 0, 2000);
      check("clamp7_cur", int'(cur_f), 6);
      dir = 1'b0;
      prev = coil_f;
      @(negedge clk);
      check("rev_at_speed", int'(at_f), 0);
      wait_pulse(100, n);
      check("rev_still_fwd", int'(coil_f), int'(rotl(prev)));
      wait_for(1, 0, 2000);
      check("rev_back_cur", int'(cur_f), 6);
      prev = coil_f;
      wait_pulse(100, n);
      check("rev_order", int'(coil_f), int'(rotr(prev)));

      // retarget 6 -> 2 without stopping
      target_speed = 3'd2;
      wait_for(2, 2, 2000);
      repeat (100) @(negedge clk);
      check("retgt_cur", int'(cur_f), 2);
      check("retgt_busy", int'(busy_f), 1);
      check("retgt_at", int'(at_f), 1);

      // target 0 holds level 1
      target_speed = 3'd0;
      wait_for(2, 1, 2000);
      repeat (100) @(negedge clk);
      check("t0_cur", int'(cur_f), 1);
      check("t0_at", int'(at_f), 1);

      // asynchronous reset while running at level 3
      target_speed = 3'd3;
      wait_for(2, 3, 2000);
      @(posedge clk);
      #2 resetb = 1'b0;
      #1;
      check("arst_coil", int'(coil_f), 0);
      check("arst_coil_h", int'(coil_h), 0);
      check("arst_cur", int'(cur_f), 0);
      check("arst_busy", int'(busy_f), 0);
      check("arst_pulse", int'(pulse_f), 0);
      @(negedge clk);
      resetb = 1'b1; dir = 1'b1; target_speed = 3'd6;
      @(negedge clk);
      check("restart_coil", int'(coil_f), 4'b0011);
      check("restart_coil_h0", int'(coil_h), int'(hexp[0]));

      // half-step sequence over 8 steps
      for (int k = 1; k <= 8; k++) begin
         wait_pulse(100, n);
         check($sformatf("half_coil_%0d", k), int'(coil_h), int'(hexp[k]));
      end

      run_en = 1'b0;
      wait_for(0, 0, 2000);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
